fp_issue: RTL and testbench
===========================

FP_ISSUE -- requirements
Module: fp_issue

Interface
REQ-001 Parameter: TIMEOUT, default 64 (range 2..255), max cycles in WAIT before an error response.
REQ-002 Parameter: OPW, default 8, width of the operation code.
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  core presents an FP operation.
REQ-006 req_ready  output  1  block can accept an operation.
REQ-007 req_op  input  OPW  operation code, passed unchanged to the FPU.
REQ-008 req_data1, req_data2, req_data3  input  32 each  operands.
REQ-009 req_rm  input  3  rounding mode.
REQ-010 fpu_enable  output  1  one-cycle issue strobe to the FP unit.
REQ-011 fpu_op, fpu_data1..3, fpu_rm  output  OPW/32/3  latched operation fields.
REQ-012 fpu_ready  input  1  FP unit result valid this cycle.
REQ-013 fpu_result  input  32, fpu_flags  input  5  result and NV,DZ,OF,UF,NX flags.
REQ-014 fpu_kill  output  1  one-cycle abort strobe to the FP unit.
REQ-015 rsp_valid  output  1, rsp_ready  input  1  response handshake.
REQ-016 rsp_result  output  32, rsp_flags  output  5, rsp_error  output  1  response payload.
REQ-017 flush  input  1  abandon the in-flight operation.
REQ-018 fflags  output  5  sticky accumulated flags; fflags_clr  input  1  clears them.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP, with req_ready=1 only in IDLE.
REQ-020 IDLE: on req_valid, latch op/data/rm into fpu_* registers and go to ISSUE next cycle.
REQ-021 ISSUE: fpu_enable=1 for exactly this cycle; if fpu_ready=1, capture result/flags and go to RESP, else go to WAIT.
REQ-022 WAIT: fpu_enable=0; a wait counter increments each cycle; on fpu_ready, capture result/flags and go to RESP.
REQ-023 Timeout: WAIT with counter==TIMEOUT-1 and fpu_ready=0 SHALL capture result 0x7FC00000, flags 5'b10000, set rsp_error=1, pulse fpu_kill, and go to RESP.
REQ-024 fpu_ready SHALL be ignored in IDLE and RESP.
REQ-025 RESP: rsp_valid=1 with stable payload until rsp_ready=1, then go to IDLE; no new request is accepted in the handshake cycle.
REQ-026 Minimum latency: request accepted cycle N, fpu_enable cycle N+1, rsp_valid cycle N+2 when fpu_ready arrives in N+1.
REQ-027 On a completed rsp handshake, fflags SHALL become fflags | rsp_flags.
REQ-028 fflags_clr SHALL zero fflags next cycle; if coincident with a handshake, the cleared value is ORed with rsp_flags.
REQ-029 flush in ISSUE or WAIT: go to IDLE next cycle, pulse fpu_kill, produce no response, leave fflags unchanged.
REQ-030 flush in RESP: drop the response, go to IDLE; flush in IDLE: no effect, and no request is accepted that cycle.
REQ-031 flush has priority over fpu_ready, timeout, and rsp_ready in the same cycle.
REQ-032 The wait counter SHALL clear on entering ISSUE and SHALL never wrap.

Reset
REQ-033 reset=1 SHALL force IDLE with all outputs and registers zero (fflags, counter, fpu_*, rsp_*); fpu_kill SHALL NOT pulse on reset.
REQ-034 reset during WAIT or RESP SHALL drop the operation silently, and any late fpu_ready after reset SHALL be ignored.

Verification
REQ-035 Single-cycle op: req add 0x3F800000+0x3F800000, fpu_ready in ISSUE with 0x40000000 -> rsp_valid at N+2, rsp_result=0x40000000, rsp_error=0.
REQ-036 Multi-cycle div: fpu_ready 10 cycles after fpu_enable with flags 00001 -> single fpu_enable pulse, rsp_flags=00001, fflags=00001 after handshake.
REQ-037 Timeout: TIMEOUT=4, fpu_ready never asserted -> fpu_kill pulses once, rsp_result=0x7FC00000, rsp_flags=10000, rsp_error=1.
REQ-038 Backpressure: rsp_ready low 5 cycles -> payload stable, req_ready=0 throughout, IDLE after handshake.
REQ-039 Flush in WAIT coincident with fpu_ready -> no rsp_valid, fpu_kill=1 for one cycle, fflags unchanged.
REQ-040 fflags_clr coincident with a handshake carrying flags 00100 while fflags=10001 -> fflags=00100.

Source files
------------

// File: rtl/fp_issue.sv
// FP issue sequencer: hands one operation at a time to the FPU, waits for its result or times it out, and returns a response.
// Latency: request accepted in cycle N, fpu_enable in N+1, rsp_valid from N+2 at the earliest. Add one cycle per WAIT cycle.
// Backpressure: req_ready is high only in IDLE. rsp_valid and its payload hold until rsp_ready. flush overrides everything.
module fp_issue #(
  parameter int TIMEOUT = 64,
  parameter int OPW     = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OPW-1:0]  req_op,
  input  logic [31:0]     req_data1,
  input  logic [31:0]     req_data2,
  input  logic [31:0]     req_data3,
  input  logic [2:0]      req_rm,
  output logic            fpu_enable,
  output logic [OPW-1:0]  fpu_op,
  output logic [31:0]     fpu_data1,
  output logic [31:0]     fpu_data2,
  output logic [31:0]     fpu_data3,
  output logic [2:0]      fpu_rm,
  input  logic            fpu_ready,
  input  logic [31:0]     fpu_result,
  input  logic [4:0]      fpu_flags,
  output logic            fpu_kill,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_result,
  output logic [4:0]      rsp_flags,
  output logic            rsp_error,
  input  logic            flush,
  output logic [4:0]      fflags,
  input  logic            fflags_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Last WAIT-cycle count value before the operation is declared lost.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [4:0]  NV_FLAG  = 5'b10000;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       rsp_hs;

  // Status outputs decode straight from the state register. A flush in IDLE refuses the request.
  assign req_ready  = (state == IDLE) && !flush && !reset;
  assign fpu_enable = (state == ISSUE);
  assign rsp_valid  = (state == RESP);
  // A response that is flushed in the same cycle counts as dropped, not delivered.
  assign rsp_hs     = (state == RESP) && rsp_ready && !flush;

  // Main sequencer: state, latched operation, captured response, kill strobe and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      fpu_op     <= '0;
      fpu_data1  <= '0;
      fpu_data2  <= '0;
      fpu_data3  <= '0;
      fpu_rm     <= '0;
      fpu_kill   <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_error  <= 1'b0;
      fflags     <= '0;
    end else begin
      fpu_kill <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            fpu_op    <= req_op;
            fpu_data1 <= req_data1;
            fpu_data2 <= req_data2;
            fpu_data3 <= req_data3;
            fpu_rm    <= req_rm;
            wait_cnt  <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush) begin
            fpu_kill <= 1'b1;
            state    <= IDLE;
          end else if (fpu_ready) begin
            rsp_result <= fpu_result;
            rsp_flags  <= fpu_flags;
            rsp_error  <= 1'b0;
            state      <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            fpu_kill <= 1'b1;
            state    <= IDLE;
          end else if (fpu_ready) begin
            rsp_result <= fpu_result;
            rsp_flags  <= fpu_flags;
            rsp_error  <= 1'b0;
            state      <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            // The FPU never answered: abort it and return a quiet NaN with the invalid flag.
            rsp_result <= QNAN;
            rsp_flags  <= NV_FLAG;
            rsp_error  <= 1'b1;
            fpu_kill   <= 1'b1;
            state      <= RESP;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (flush || rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // The clear applies first, so a flag delivered in the same cycle survives.
      fflags <= (fflags_clr ? 5'b00000 : fflags) | (rsp_hs ? rsp_flags : 5'b00000);
    end
  end

endmodule

// File: tb/tb_fp_issue.sv
// Scoreboard bench for fp_issue. One instance uses the default timeout, and a second uses a short timeout.
// Responses are predicted when an operation is driven and compared at the response handshake.
// Both instances share all inputs.
module tb_fp_issue;

  localparam int OPW = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            req_valid;
  logic [OPW-1:0]  req_op;
  logic [31:0]     req_data1, req_data2, req_data3;
  logic [2:0]      req_rm;
  logic            fpu_ready;
  logic [31:0]     fpu_result;
  logic [4:0]      fpu_flags;
  logic            rsp_ready;
  logic            flush;
  logic            fflags_clr;

  logic            req_ready, fpu_enable, fpu_kill, rsp_valid, rsp_error;
  logic [OPW-1:0]  fpu_op;
  logic [31:0]     fpu_data1, fpu_data2, fpu_data3, rsp_result;
  logic [2:0]      fpu_rm;
  logic [4:0]      rsp_flags, fflags;

  logic            t_req_ready, t_fpu_enable, t_fpu_kill, t_rsp_valid, t_rsp_error;
  logic [OPW-1:0]  t_fpu_op;
  logic [31:0]     t_fpu_data1, t_fpu_data2, t_fpu_data3, t_rsp_result;
  logic [2:0]      t_fpu_rm;
  logic [4:0]      t_rsp_flags, t_fflags;

  always #5 clock = ~clock;

  fp_issue #(.TIMEOUT(64), .OPW(OPW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3), .req_rm(req_rm),
    .fpu_enable(fpu_enable), .fpu_op(fpu_op),
    .fpu_data1(fpu_data1), .fpu_data2(fpu_data2), .fpu_data3(fpu_data3), .fpu_rm(fpu_rm),
    .fpu_ready(fpu_ready), .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_kill(fpu_kill),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_error(rsp_error),
    .flush(flush), .fflags(fflags), .fflags_clr(fflags_clr)
  );

  fp_issue #(.TIMEOUT(4), .OPW(OPW)) dut_t (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(t_req_ready), .req_op(req_op),
    .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3), .req_rm(req_rm),
    .fpu_enable(t_fpu_enable), .fpu_op(t_fpu_op),
    .fpu_data1(t_fpu_data1), .fpu_data2(t_fpu_data2), .fpu_data3(t_fpu_data3), .fpu_rm(t_fpu_rm),
    .fpu_ready(fpu_ready), .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_kill(t_fpu_kill),
    .rsp_valid(t_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(t_rsp_result),
    .rsp_flags(t_rsp_flags), .rsp_error(t_rsp_error),
    .flush(flush), .fflags(t_fflags), .fflags_clr(fflags_clr)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_en   = 0;
  int   n_kill = 0;
  int   n_rv   = 0;
  int   n_tkill = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Pulse counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (fpu_enable)  n_en++;
    if (fpu_kill)    n_kill++;
    if (rsp_valid)   n_rv++;
    if (t_fpu_kill)  n_tkill++;
  end

  // Response monitor: a handshake happens at the next rising edge if these hold now.
  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_result), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_flags",  64'(rsp_flags),  64'(e.flg));
        chk("rsp_error",  64'(rsp_error),  64'(e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present an operation and hold it until accepted. Returns one step into the ISSUE cycle.
  task automatic send_req(input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [2:0] rm);
    int k;
    req_valid = 1'b1;
    req_op = op; req_data1 = a; req_data2 = b; req_data3 = c; req_rm = rm;
    k = 0;
    @(negedge clock);
    while (!req_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("req_accept", 64'(req_ready), 64'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int lim);
    int k;
    k = 0;
    while (!rsp_valid && k < lim) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 64'(rsp_valid), 64'd1);
  endtask

  task automatic handshake(input logic clr);
    @(posedge clock);
    #1;
    rsp_ready  = 1'b1;
    fflags_clr = clr;
    @(posedge clock);
    #1;
    rsp_ready  = 1'b0;
    fflags_clr = 1'b0;
  endtask

  // One operation answered by the FPU in the issue cycle.
  task automatic quick_op(input logic [31:0] res, input logic [4:0] flg, input logic push);
    send_req(8'h01, 32'h1, 32'h2, 32'h3, 3'd0);
    fpu_ready = 1'b1; fpu_result = res; fpu_flags = flg;
    if (push) exp_q.push_back('{res: res, flg: flg, err: 1'b0});
    tick();
    fpu_ready = 1'b0;
  endtask

  initial begin
    int k0, k1, e0;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_data1 = '0; req_data2 = '0; req_data3 = '0;
    req_rm = '0; fpu_ready = 1'b0; fpu_result = '0; fpu_flags = '0; rsp_ready = 1'b0;
    flush = 1'b0; fflags_clr = 1'b0;

    // Reset state.
    repeat (3) tick();
    @(negedge clock);
    chk("rst_req_ready",  64'(req_ready), 64'd0);
    chk("rst_fpu_enable", 64'(fpu_enable), 64'd0);
    chk("rst_fpu_kill",   64'(fpu_kill), 64'd0);
    chk("rst_rsp_valid",  64'(rsp_valid), 64'd0);
    chk("rst_fflags",     64'(fflags), 64'd0);
    chk("rst_fpu_data1",  64'(fpu_data1), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    tick();

    // Single-cycle add: enable in N+1, response in N+2.
    send_req(8'h10, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 3'd2);
    fpu_ready = 1'b1; fpu_result = 32'h4000_0000; fpu_flags = 5'b00000;
    exp_q.push_back('{res: 32'h4000_0000, flg: 5'b00000, err: 1'b0});
    @(negedge clock);
    chk("add_enable", 64'(fpu_enable), 64'd1);
    chk("add_op",     64'(fpu_op), 64'h10);
    chk("add_data1",  64'(fpu_data1), 64'h3F80_0000);
    chk("add_rm",     64'(fpu_rm), 64'd2);
    chk("add_no_rsp_n1", 64'(rsp_valid), 64'd0);
    tick();
    fpu_ready = 1'b0;
    @(negedge clock);
    chk("add_rsp_n2",    64'(rsp_valid), 64'd1);
    chk("add_enable_off", 64'(fpu_enable), 64'd0);
    handshake(1'b0);
    @(negedge clock);
    chk("add_back_idle", 64'(req_ready), 64'd1);
    tick();

    // Multi-cycle divide: the result arrives 10 cycles after the issue strobe.
    e0 = n_en;
    send_req(8'h20, 32'h4120_0000, 32'h4040_0000, 32'h0, 3'd0);
    repeat (10) tick();
    fpu_ready = 1'b1; fpu_result = 32'h4055_5555; fpu_flags = 5'b00001;
    exp_q.push_back('{res: 32'h4055_5555, flg: 5'b00001, err: 1'b0});
    tick();
    fpu_ready = 1'b0;
    @(negedge clock);
    wait_rsp("div_rsp_wait", 20);
    handshake(1'b0);
    @(negedge clock);
    chk("div_single_enable", 64'(n_en - e0), 64'd1);
    chk("div_fflags", 64'(fflags), 64'b00001);
    tick();

    // Backpressure: rsp_ready stays low for 5 cycles with a competing request.
    quick_op(32'h1234_5678, 5'b00010, 1'b1);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_valid",     64'(rsp_valid), 64'd1);
      chk("bp_result",    64'(rsp_result), 64'h1234_5678);
      chk("bp_flags",     64'(rsp_flags), 64'b00010);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    chk("bp_idle_after", 64'(req_ready), 64'd1);
    chk("bp_no_accept",  64'(fpu_enable), 64'd0);
    chk("bp_fflags",     64'(fflags), 64'b00011);
    tick();

    // Sticky-flag clear, alone and coincident with a handshake.
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    @(negedge clock);
    chk("clr_alone", 64'(fflags), 64'd0);
    tick();
    quick_op(32'h0000_0001, 5'b10001, 1'b1);
    handshake(1'b0);
    @(negedge clock);
    chk("fflags_10001", 64'(fflags), 64'b10001);
    tick();
    quick_op(32'h0000_0002, 5'b00100, 1'b1);
    handshake(1'b1);
    @(negedge clock);
    chk("clr_with_hs", 64'(fflags), 64'b00100);
    tick();

    // Flush in IDLE blocks acceptance.
    flush = 1'b1; req_valid = 1'b1;
    @(negedge clock);
    chk("flush_idle_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    chk("flush_idle_no_issue", 64'(fpu_enable), 64'd0);
    tick();

    // Flush in WAIT coincident with fpu_ready.
    send_req(8'h30, 32'h5, 32'h6, 32'h7, 3'd1);
    tick();
    tick();
    k0 = n_kill; k1 = n_rv;
    flush = 1'b1; fpu_ready = 1'b1; fpu_result = 32'hDEAD_BEEF; fpu_flags = 5'b11111;
    tick();
    flush = 1'b0; fpu_ready = 1'b0;
    @(negedge clock);
    chk("flush_wait_kill", 64'(fpu_kill), 64'd1);
    chk("flush_wait_no_rsp", 64'(rsp_valid), 64'd0);
    repeat (4) @(negedge clock);
    chk("flush_wait_kill_once", 64'(n_kill - k0), 64'd1);
    chk("flush_wait_no_rv",     64'(n_rv - k1), 64'd0);
    chk("flush_wait_fflags",    64'(fflags), 64'b00100);
    chk("flush_wait_idle",      64'(req_ready), 64'd1);
    tick();

    // Flush in RESP drops the response, even with rsp_ready high.
    quick_op(32'hCAFE_0000, 5'b01000, 1'b0);
    flush = 1'b1; rsp_ready = 1'b1;
    tick();
    flush = 1'b0; rsp_ready = 1'b0;
    @(negedge clock);
    chk("flush_resp_dropped", 64'(rsp_valid), 64'd0);
    chk("flush_resp_fflags",  64'(fflags), 64'b00100);
    tick();

    // Reset during WAIT, then a late fpu_ready.
    send_req(8'h40, 32'h8, 32'h9, 32'hA, 3'd3);
    tick();
    k0 = n_kill;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    fpu_ready = 1'b1; fpu_result = 32'h1111_1111; fpu_flags = 5'b00010;
    tick();
    tick();
    fpu_ready = 1'b0;
    @(negedge clock);
    chk("rst_wait_no_rsp",  64'(rsp_valid), 64'd0);
    chk("rst_wait_no_kill", 64'(n_kill - k0), 64'd0);
    chk("rst_wait_fflags",  64'(fflags), 64'd0);
    chk("rst_wait_result",  64'(rsp_result), 64'd0);
    chk("rst_wait_idle",    64'(req_ready), 64'd1);
    tick();

    // Timeout on the short-timeout instance (TIMEOUT=4).
    k0 = n_tkill;
    send_req(8'h50, 32'h1, 32'h0, 32'h0, 3'd0);
    begin
      int k;
      k = 0;
      @(negedge clock);
      while (!t_rsp_valid && k < 20) begin
        @(negedge clock);
        k++;
      end
      chk("to_latency", 64'(k), 64'd5);
    end
    chk("to_result", 64'(t_rsp_result), 64'h7FC0_0000);
    chk("to_flags",  64'(t_rsp_flags), 64'b10000);
    chk("to_error",  64'(t_rsp_error), 64'd1);
    handshake(1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) @(negedge clock);
    chk("to_kill_once", 64'(n_tkill - k0), 64'd1);
    chk("to_idle",      64'(t_rsp_valid), 64'd0);
    chk("to_fflags",    64'(t_fflags), 64'b10000);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
